clkgen_rst_seq: RTL and testbench

- Parametrised clock/reset generator. Successor to the single-channel pass-through clkgen.
- Sits after the board clock input buffer and PLL.
- Takes one buffered system clock, an async board reset and a PLL lock indication. Produces NUM_RST staggered, synchronously-released resets plus NUM_CLKEN programmable clock-enable strobes for slow peripherals.
- Re-enters reset on PLL lock loss or software request.

---
 rtl/clkgen_pkg.sv | 23 ++
 rtl/clkgen_sync.sv | 25 ++
 rtl/clkgen_rst_seq.sv | 209 ++++++++++++++++++++
 tb/tb_clkgen_rst_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and constants for the clock/reset generator.
// The state encoding is exported on state_o for debug visibility.
package clkgen_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } rst_seq_state_e;

    localparam int CLKGEN_SYNC_STAGES_DEF = 2;
    localparam int CLKGEN_HOLD_CYCLES_DEF = 16;

    // Width needed to hold max(a, b) without overflow.
    function automatic int clog2_max(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clkgen_sync.sv
// Generic multi-flop synchroniser with asynchronous active-low clear.
// Used both for reset-release (d tied high) and for the PLL lock input.
module clkgen_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/clkgen_rst_seq.sv
// Staggered reset sequencer plus programmable clock-enable strobes.
// Define CLKGEN_RST_SEQ_SW_RST_EN to honour sw_rst_req_i in RELEASE/RUN.
module clkgen_rst_seq
    import clkgen_pkg::*;
#(
    parameter int NUM_RST        = 4,
    parameter int SYNC_STAGES    = CLKGEN_SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES    = CLKGEN_HOLD_CYCLES_DEF,
    parameter int STAGGER_CYCLES = 8,
    parameter int NUM_CLKEN      = 2,
    parameter int DIV_W          = 8
) (
    input  logic                       IO_CLK,
    input  logic                       IO_RST_N,
    input  logic                       locked_i,
    input  logic                       sw_rst_req_i,
    input  logic [NUM_CLKEN*DIV_W-1:0] div_i,
    output logic [NUM_RST-1:0]         rst_n_o,
    output logic [NUM_CLKEN-1:0]       clk_en_o,
    output logic                       busy_o,
    output logic [2:0]                 state_o
);

    localparam int              CNT_W     = clog2_max(HOLD_CYCLES, NUM_RST * STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((NUM_RST - 1) * STAGGER_CYCLES);

    rst_seq_state_e   state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             rst_sync_n;
    logic             lock_s;
    logic             drop_now;

    clkgen_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_rst_sync (
        .clk   (IO_CLK),
        .rst_n (IO_RST_N),
        .d     (1'b1),
        .q     (rst_sync_n)
    );

    clkgen_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_lock_sync (
        .clk   (IO_CLK),
        .rst_n (IO_RST_N),
        .d     (locked_i),
        .q     (lock_s)
    );

`ifndef CLKGEN_RST_SEQ_SW_RST_EN
    logic unused_sw_rst_req;
    assign unused_sw_rst_req = sw_rst_req_i;
`endif

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign state_o = state;

    // Re-assertion condition, needed by the enable channels so they go quiet
    // on the same edge that drops the resets.
    always_comb begin
        drop_now = 1'b0;
        case (state)
            ST_RESET, ST_WAIT_LOCK:       drop_now = 1'b0;
            ST_HOLD, ST_RELEASE, ST_RUN:  drop_now = !lock_s;
            default:                      drop_now = 1'b1;
        endcase
`ifdef CLKGEN_RST_SEQ_SW_RST_EN
        if ((state == ST_RELEASE || state == ST_RUN) && sw_rst_req_i) begin
            drop_now = 1'b1;
        end
`endif
    end

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            state   <= ST_RESET;
            cnt     <= '0;
            rst_n_o <= '0;
            busy_o  <= 1'b1;
        end else begin
            case (state)
                ST_RESET: begin
                    if (rst_sync_n) begin
                        state <= ST_WAIT_LOCK;
                    end
                end

                ST_WAIT_LOCK: begin
                    cnt <= '0;
                    if (lock_s) begin
                        state <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (!lock_s) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        rst_n_o <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        cnt        <= '0;
                        rst_n_o[0] <= 1'b1;
                        if (NUM_RST == 1) begin
                            state  <= ST_RUN;
                            busy_o <= 1'b0;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                ST_RELEASE: begin
                    if (!lock_s) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        rst_n_o <= '0;
                    end
`ifdef CLKGEN_RST_SEQ_SW_RST_EN
                    else if (sw_rst_req_i) begin
                        state   <= ST_HOLD;
                        cnt     <= '0;
                        rst_n_o <= '0;
                    end
`endif
                    else begin
                        cnt <= cnt_inc;
                        // Bit i releases once the counter reaches i*STAGGER_CYCLES.
                        for (int i = 1; i < NUM_RST; i++) begin
                            if (cnt_inc == CNT_W'(i * STAGGER_CYCLES)) begin
                                rst_n_o[i] <= 1'b1;
                            end
                        end
                        if (cnt_inc == REL_LAST) begin
                            state  <= ST_RUN;
                            busy_o <= 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (!lock_s) begin
                        state   <= ST_WAIT_LOCK;
                        cnt     <= '0;
                        rst_n_o <= '0;
                        busy_o  <= 1'b1;
                    end
`ifdef CLKGEN_RST_SEQ_SW_RST_EN
                    else if (sw_rst_req_i) begin
                        state   <= ST_HOLD;
                        cnt     <= '0;
                        rst_n_o <= '0;
                        busy_o  <= 1'b1;
                    end
`endif
                end

                default: begin
                    state   <= ST_RESET;
                    cnt     <= '0;
                    rst_n_o <= '0;
                    busy_o  <= 1'b1;
                end
            endcase
        end
    end

    // Divider channels run only while the first domain is out of reset.
    for (genvar k = 0; k < NUM_CLKEN; k++) begin : g_clken
        logic [DIV_W-1:0] div_cnt;
        logic [DIV_W-1:0] div_q;
        logic             en_q;
        logic [DIV_W-1:0] div_k;

        assign div_k       = div_i[k*DIV_W +: DIV_W];
        assign clk_en_o[k] = en_q;

        always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
            if (!IO_RST_N) begin
                div_cnt <= '0;
                div_q   <= '0;
                en_q    <= 1'b0;
            end else if (drop_now || !rst_n_o[0]) begin
                div_cnt <= '0;
                div_q   <= div_k;
                en_q    <= 1'b0;
            end else if (div_cnt == div_q) begin
                div_cnt <= '0;
                div_q   <= div_k;
                en_q    <= 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
                en_q    <= 1'b0;
                // A wrap through all-ones is a reload without a pulse.
                if (div_cnt == {DIV_W{1'b1}}) begin
                    div_q <= div_k;
                end
            end
        end
    end

endmodule

// File: tb/tb_clkgen_rst_seq.sv
// Directed-plus-random bench for clkgen_rst_seq against a timeline model
// (cycles since hold entry, countdown to next enable pulse).
module tb_clkgen_rst_seq;

    localparam int NUM_RST   = 4;
    localparam int SYNC      = 2;
    localparam int HOLD      = 16;
    localparam int STAG      = 8;
    localparam int NUM_CLKEN = 2;
    localparam int DIV_W     = 8;
`ifdef CLKGEN_RST_SEQ_SW_RST_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic                       IO_CLK = 1'b0;
    logic                       IO_RST_N;
    logic                       locked_i;
    logic                       sw_rst_req_i;
    logic [NUM_CLKEN*DIV_W-1:0] div_i;
    logic [NUM_RST-1:0]         rst_n_o;
    logic [NUM_CLKEN-1:0]       clk_en_o;
    logic                       busy_o;
    logic [2:0]                 state_o;

    clkgen_rst_seq #(
        .NUM_RST        (NUM_RST),
        .SYNC_STAGES    (SYNC),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG),
        .NUM_CLKEN      (NUM_CLKEN),
        .DIV_W          (DIV_W)
    ) dut (
        .IO_CLK       (IO_CLK),
        .IO_RST_N     (IO_RST_N),
        .locked_i     (locked_i),
        .sw_rst_req_i (sw_rst_req_i),
        .div_i        (div_i),
        .rst_n_o      (rst_n_o),
        .clk_en_o     (clk_en_o),
        .busy_o       (busy_o),
        .state_o      (state_o)
    );

    // Clock and watchdog
    always #5 IO_CLK = ~IO_CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;
    int rise_at[NUM_RST];
    int busy_fall_at;
    logic [7:0] exp_q[$];

    // Reference model: mode 0=reset, 1=waiting for lock, 2=sequencing (m_k = edges since hold entry)
    int   m_rs_cnt;
    bit   m_lk[SYNC];
    int   m_mode;
    int   m_k;
    int   m_remain[NUM_CLKEN];
    bit   m_en[NUM_CLKEN];
    logic [NUM_RST-1:0]   exp_rst;
    logic [NUM_CLKEN-1:0] exp_en;
    logic                 exp_busy;
    logic [2:0]           exp_state;

    function automatic void model_outputs();
        for (int i = 0; i < NUM_RST; i++)
            exp_rst[i] = (m_mode == 2) && (m_k >= HOLD + i * STAG);
        for (int c = 0; c < NUM_CLKEN; c++)
            exp_en[c] = m_en[c];
        exp_busy = !((m_mode == 2) && (m_k >= HOLD + (NUM_RST - 1) * STAG));
        if (m_mode == 0)      exp_state = 3'd0;
        else if (m_mode == 1) exp_state = 3'd1;
        else if (m_k < HOLD)  exp_state = 3'd2;
        else if (exp_busy)    exp_state = 3'd3;
        else                  exp_state = 3'd4;
    endfunction

    function automatic void model_reset();
        m_rs_cnt = 0;
        for (int i = 0; i < SYNC; i++) m_lk[i] = 1'b0;
        m_mode = 0;
        m_k    = 0;
        for (int c = 0; c < NUM_CLKEN; c++) begin
            m_remain[c] = 0;
            m_en[c]     = 1'b0;
        end
        model_outputs();
    endfunction

    function automatic void model_edge();
        bit old_rsync, old_lock, old_rst0, new_rst0;
        int d;
        old_rsync = (m_rs_cnt >= SYNC);
        old_lock  = m_lk[SYNC-1];
        old_rst0  = (m_mode == 2) && (m_k >= HOLD);
        for (int i = SYNC - 1; i > 0; i--) m_lk[i] = m_lk[i-1];
        m_lk[0] = locked_i;
        if (m_rs_cnt < 1000) m_rs_cnt++;
        case (m_mode)
            0: if (old_rsync) m_mode = 1;
            1: if (old_lock) begin m_mode = 2; m_k = 0; end
            default: begin
                if (!old_lock)                                  m_mode = 1;
                else if (SW_EN && sw_rst_req_i && m_k >= HOLD)  m_k = 0;
                else if (m_k < 1000)                            m_k++;
            end
        endcase
        new_rst0 = (m_mode == 2) && (m_k >= HOLD);
        for (int c = 0; c < NUM_CLKEN; c++) begin
            d = int'(div_i[c*DIV_W +: DIV_W]);
            if (!new_rst0) begin
                m_en[c] = 1'b0;
            end else if (!old_rst0) begin
                m_remain[c] = d + 1;
                m_en[c]     = 1'b0;
            end else begin
                m_remain[c]--;
                m_en[c] = (m_remain[c] == 0);
                if (m_remain[c] == 0) m_remain[c] = d + 1;
            end
        end
        model_outputs();
    endfunction

    // Scoreboard
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_all();
        check_eq("rst_n_o",  32'(rst_n_o),  32'(exp_rst));
        check_eq("clk_en_o", 32'(clk_en_o), 32'(exp_en));
        check_eq("busy_o",   32'(busy_o),   32'(exp_busy));
        check_eq("state_o",  32'(state_o),  32'(exp_state));
    endtask

    // Driver tasks
    task automatic step();
        @(posedge IO_CLK);
        if (IO_RST_N) model_edge();
        #1;
        edge_n++;
        check_all();
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < NUM_RST; i++) rise_at[i] = -1;
        busy_fall_at = -1;
        edge_n = 0;
        repeat (n) begin
            step();
            for (int i = 0; i < NUM_RST; i++)
                if (rise_at[i] < 0 && rst_n_o[i] === 1'b1) rise_at[i] = edge_n;
            if (busy_fall_at < 0 && busy_o === 1'b0) busy_fall_at = edge_n;
        end
    endtask

    task automatic wait_run();
        int b;
        b = 0;
        while (exp_busy && b < 200) begin
            step();
            b++;
        end
        check_eq("reach_run", 32'(busy_o), 32'(0));
    endtask

    task automatic count_to_rst0(input string tag, input int want);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            n++;
            if (rst_n_o[0] === 1'b1) found = 1'b1;
        end
        check_eq(tag, 32'(found ? n : -1), 32'(want));
    endtask

    initial begin
        int ones0, ones1;
        exp_q = '{8'd20, 8'd28, 8'd36, 8'd44};
        IO_RST_N     = 1'b0;
        locked_i     = 1'b1;
        sw_rst_req_i = 1'b0;
        div_i        = '0;
        model_reset();

        // Power-up
        repeat (3) step();
        #2 IO_RST_N = 1'b1;
        capture(50);
        for (int i = 0; i < NUM_RST; i++)
            check_eq($sformatf("pwr_rise%0d", i), 32'(rise_at[i]), 32'(exp_q[i]));
        check_eq("pwr_busy_fall", 32'(busy_fall_at), 32'(44));
        check_eq("pwr_state_run", 32'(state_o), 32'(4));

        // Asynchronous reset pulse mid-cycle, then replay
        #2 IO_RST_N = 1'b0;
        #1;
        check_eq("async_rst_n_o",  32'(rst_n_o),  32'(0));
        check_eq("async_clk_en_o", 32'(clk_en_o), 32'(0));
        check_eq("async_state",    32'(state_o),  32'(0));
        model_reset();
        #2 IO_RST_N = 1'b1;
        capture(30);
        check_eq("replay_rise0", 32'(rise_at[0]), 32'(exp_q[0]));
        check_eq("replay_rise1", 32'(rise_at[1]), 32'(exp_q[1]));

        // Lock loss during RELEASE, then relock
        locked_i = 1'b0;
        repeat (10) step();
        check_eq("lockloss_state", 32'(state_o), 32'(1));
        check_eq("lockloss_rst",   32'(rst_n_o), 32'(0));
        locked_i = 1'b1;
        count_to_rst0("relock_edges", 2 + 1 + HOLD);
        wait_run();

        // Divider: ch0 divide 0, ch1 divide 3, then 1 mid-period
        div_i = {8'd3, 8'd0};
        repeat (9) step();
        div_i = {8'd1, 8'd0};
        repeat (6) step();
        ones0 = 0;
        ones1 = 0;
        repeat (8) begin
            step();
            ones0 += int'(clk_en_o[0]);
            ones1 += int'(clk_en_o[1]);
        end
        check_eq("div0_ones", 32'(ones0), 32'(8));
        check_eq("div1_ones", 32'(ones1), 32'(4));

        // Software reset in RUN
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        if (SW_EN) begin
            check_eq("sw_rst_state", 32'(state_o), 32'(2));
            check_eq("sw_rst_drop",  32'(rst_n_o), 32'(0));
            count_to_rst0("sw_rst_rise0", HOLD);
        end else begin
            check_eq("sw_ign_busy",  32'(busy_o),  32'(0));
            check_eq("sw_ign_state", 32'(state_o), 32'(4));
            repeat (HOLD) step();
        end
        wait_run();

        // Lock loss and software request seen on the same edge
        locked_i = 1'b0;
        step();
        step();
        sw_rst_req_i = 1'b1;
        step();
        sw_rst_req_i = 1'b0;
        check_eq("lock_wins_state", 32'(state_o), 32'(1));
        locked_i = 1'b1;
        wait_run();

        // Randomised traffic
        repeat (400) begin
            if (locked_i) begin
                if ($urandom_range(0, 99) < 1) locked_i = 1'b0;
            end else if ($urandom_range(0, 9) < 2) begin
                locked_i = 1'b1;
            end
            sw_rst_req_i = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0)
                div_i = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
            step();
        end
        sw_rst_req_i = 1'b0;

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
